icache_ctrl: RTL and testbench
==============================

// Module: icache_ctrl
// PURPOSE
//  Direct-mapped, read-only instruction cache between the PC register and the
//  line-wide instruction memory. Looks up PC each cycle and returns the instruction.
//  On a miss it raises stall_o, which drives the PC's mem_stall input, and refills one line.
//  Hits complete combinationally in the same cycle.
// PARAMETERS
//  LINE_WORDS  8   32-bit words per line; power of 2, at least 2
//  NUM_LINES   32  cache lines; power of 2; capacity = NUM_LINES*LINE_WORDS*4 bytes
// PORTS
//  clk_i       in   1               clock; all state on posedge
//  rst_i       in   1               reset; asynchronous, active-high
//  req_i       in   1               fetch valid (PC running)
//  addr_i      in   32              fetch byte address from PC; bits[1:0] ignored
//  instr_o     out  32              fetched instruction; 32'h0 when no hit
//  stall_o     out  1               1 = instruction not ready; hold PC
//  mem_req_o   out  1               refill request, level; held until mem_ack_i
//  mem_addr_o  out  32              refill line address, line-aligned
//  mem_ack_i   in   1               1-cycle pulse: mem_data_i is valid this cycle
//  mem_data_i  in   LINE_WORDS*32   full line; word w = bits[32*w +: 32]
//  hit_cnt_o   out  32              hit count (ICACHE_STATS_EN only)
//  miss_cnt_o  out  32              miss count (ICACHE_STATS_EN only)
// BEHAVIOUR
//  Address split:
//   word = addr_i[2 +: log2(LINE_WORDS)]
//   index = next log2(NUM_LINES) bits
//   tag = remaining upper bits
//  Storage: per line a valid bit, tag and data. No replacement choice: direct-mapped.
//  Reset (async): all valid bits = 0, state = IDLE, mem_req_o = 0, mem_addr_o = 0,
//   counters = 0. Outputs: stall_o = 0, instr_o = 0.
//  FSM states: IDLE, MISS, REFILL.
//   IDLE, req_i=0: stall_o=0, instr_o=0, no state change.
//   IDLE, hit (valid & tag match): instr_o = data word, stall_o=0. Zero latency.
//   IDLE, miss: stall_o=1 in the same cycle. Latch line address into mem_addr_o.
//    Next state MISS.
//   MISS: mem_req_o=1, stall_o=1. On a cycle with mem_ack_i=1:
//    write line data, set tag and valid=1. Next state REFILL.
//   REFILL: stall_o=1, mem_req_o=0. Next state IDLE, where the re-lookup hits.
//  Miss penalty = (cycles in MISS) + 2.
//  addr_i is stable while stall_o=1, because the PC holds.
//  If req_i drops during MISS/REFILL, the refill still completes and updates the line.
//  mem_ack_i outside MISS is ignored; the array is not written.
//  Conflict miss overwrites the resident line unconditionally; no write-back (read-only).
//  Reset asserted mid-miss: FSM returns to IDLE at once and mem_req_o drops.
//   All valid bits are cleared. A late ack after reset is ignored.
//  Same-cycle ack and reset: reset wins.
// CONFIGURATION
//  ICACHE_STATS_EN defined:
//   hit_cnt_o increments once per IDLE hit cycle with req_i=1.
//   miss_cnt_o increments once per IDLE->MISS transition.
//   Both are 32-bit, wrap modulo 2^32, and clear on reset.
//  ICACHE_STATS_EN undefined: both ports are tied to 32'h0, with no counter logic.
// TESTING
//  1 Cold miss: reset, req_i=1, addr 0x0, ack on 3rd MISS cycle.
//    -> stall_o=1 for 5 cycles, mem_addr_o=0x0, then instr_o = word0, stall_o=0.
//  2 Sequential: after test 1, addr 0x4..0x1C one per cycle.
//    -> 7 hits, stall_o=0 throughout, instr_o = words 1..7, mem_req_o never set.
//  3 Conflict: addr 0x400, then 0x0 (defaults: 1 KB cache).
//    -> both miss, mem_addr_o=0x400 then 0x0, data correct after each refill.
//  4 Reset mid-miss: rst_i pulsed while in MISS, ack arrives 2 cycles later.
//    -> mem_req_o=0 immediately, ack ignored, next access to 0x0 misses again.
//  5 Idle/spurious: req_i=0 for 10 cycles with random mem_ack_i pulses.
//    -> stall_o=0, instr_o=0, mem_req_o=0, no line becomes valid.
//  6 Stats (ICACHE_STATS_EN): replay tests 1-3.
//    -> hit_cnt_o=10 (the 8 line-0 hits of tests 1-2 plus the re-lookup hits after
//       the 2 refills in test 3), miss_cnt_o=3.
//    Without the macro both read 0.

Source files
------------

// File: rtl/icache_ctrl.sv
// icache_ctrl -- direct-mapped, read-only instruction cache.
//
// Sits between the PC register and a line-wide instruction memory. Every cycle
// the fetch address is looked up; a hit returns the instruction in the same
// cycle. A miss raises stall_o (which holds the PC) and fetches one full line.
//
// Optional build macro: ICACHE_STATS_EN -- enables the 32-bit hit/miss
// counters. Without it, hit_cnt_o and miss_cnt_o are tied to zero.
//
// Ports:
//   clk_i       clock, all state on posedge
//   rst_i       asynchronous, active-high reset
//   req_i       fetch valid (PC running)
//   addr_i      fetch byte address; bits [1:0] ignored
//   instr_o     fetched instruction, zero when there is no hit
//   stall_o     instruction not ready; PC must hold
//   mem_req_o   refill request, held until mem_ack_i
//   mem_addr_o  line-aligned refill address
//   mem_ack_i   one-cycle pulse: mem_data_i valid this cycle
//   mem_data_i  full line, word w at bits [32*w +: 32]
//   hit_cnt_o   hit counter (stats build only)
//   miss_cnt_o  miss counter (stats build only)

module icache_ctrl #(
    parameter int LINE_WORDS = 8,
    parameter int NUM_LINES  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_i,
    input  logic [31:0]                addr_i,
    output logic [31:0]                instr_o,
    output logic                       stall_o,
    output logic                       mem_req_o,
    output logic [31:0]                mem_addr_o,
    input  logic                       mem_ack_i,
    input  logic [LINE_WORDS*32-1:0]   mem_data_i,
    output logic [31:0]                hit_cnt_o,
    output logic [31:0]                miss_cnt_o
);

    localparam int WORD_BITS  = $clog2(LINE_WORDS);
    localparam int INDEX_BITS = $clog2(NUM_LINES);
    localparam int OFF_BITS   = WORD_BITS + 2;
    localparam int TAG_BITS   = 32 - OFF_BITS - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MISS   = 2'd1,
        REFILL = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Line storage. Only the valid bits need a reset; tag and data are
    // meaningless while the line is invalid.
    logic [NUM_LINES-1:0]           valid_q;
    logic [TAG_BITS-1:0]            tag_q  [NUM_LINES];
    logic [LINE_WORDS-1:0][31:0]    data_q [NUM_LINES];

    // Lookup fields of the current fetch address
    logic [WORD_BITS-1:0]  word_sel;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  line_hit;

    // Byte-offset bits of a word address carry no information here
    logic unused_addr_bits;
    assign unused_addr_bits = &addr_i[1:0];

    assign word_sel = addr_i[2 +: WORD_BITS];
    assign index    = addr_i[OFF_BITS +: INDEX_BITS];
    assign tag      = addr_i[31 -: TAG_BITS];
    assign line_hit = valid_q[index] && (tag_q[index] == tag);

    // Refill target comes from the latched line address rather than addr_i,
    // so the line still lands in the right slot if req_i drops mid-refill.
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  fill_we;

    assign fill_index = mem_addr_o[OFF_BITS +: INDEX_BITS];
    assign fill_tag   = mem_addr_o[31 -: TAG_BITS];
    // Acks outside MISS are spurious and never touch the array. Reset forces
    // state_q to IDLE asynchronously, so a same-cycle ack is also dropped.
    assign fill_we    = (state_q == MISS) && mem_ack_i;

    logic miss_start;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        instr_o    = 32'h0;
        stall_o    = 1'b0;
        mem_req_o  = 1'b0;
        miss_start = 1'b0;
        case (state_q)
            IDLE: begin
                // While reset is held the outputs stay quiet even if the PC
                // is presenting a request.
                if (req_i && !rst_i) begin
                    if (line_hit) begin
                        instr_o = data_q[index][word_sel];
                    end else begin
                        stall_o    = 1'b1;
                        miss_start = 1'b1;
                        state_d    = MISS;
                    end
                end
            end
            MISS: begin
                stall_o   = 1'b1;
                mem_req_o = 1'b1;
                if (mem_ack_i) state_d = REFILL;
            end
            REFILL: begin
                // One bubble so the next IDLE cycle re-looks up and hits
                stall_o = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Refill address latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)           mem_addr_o <= 32'h0;
        else if (miss_start) mem_addr_o <= {addr_i[31:OFF_BITS], {OFF_BITS{1'b0}}};
    end

    // ------------------------------------------------------------------
    // Line array
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        valid_q             <= '0;
        else if (fill_we) valid_q[fill_index] <= 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (fill_we) begin
            tag_q[fill_index]  <= fill_tag;
            data_q[fill_index] <= mem_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef ICACHE_STATS_EN
    logic count_hit;
    assign count_hit = (state_q == IDLE) && req_i && line_hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_o  <= 32'h0;
            miss_cnt_o <= 32'h0;
        end else begin
            if (count_hit)  hit_cnt_o  <= hit_cnt_o + 32'd1;
            if (miss_start) miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`else
    assign hit_cnt_o  = 32'h0;
    assign miss_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl (default geometry: 8 words x 32 lines).
// The stimulus thread pushes the instruction each fetch should eventually
// return; a monitor pops and compares whenever the cache delivers one
// (req_i high, stall_o low). Control-path checks run inline.
module tb_icache_ctrl;

    localparam int LW = 8;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            req_i;
    logic [31:0]     addr_i;
    logic [31:0]     instr_o;
    logic            stall_o;
    logic            mem_req_o;
    logic [31:0]     mem_addr_o;
    logic            mem_ack_i;
    logic [LW*32-1:0] mem_data_i;
    logic [31:0]     hit_cnt_o;
    logic [31:0]     miss_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    icache_ctrl #(.LINE_WORDS(LW), .NUM_LINES(32)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .addr_i     (addr_i),
        .instr_o    (instr_o),
        .stall_o    (stall_o),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_ack_i  (mem_ack_i),
        .mem_data_i (mem_data_i),
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: each word holds its own byte address xor a marker
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [LW*32-1:0] line_of(input logic [31:0] a);
        logic [LW*32-1:0] l;
        logic [31:0] base;
        base = {a[31:5], 5'b0};
        for (int w = 0; w < LW; w++) l[32*w +: 32] = mem_word(base + 32'(w * 4));
        return l;
    endfunction

    // Monitor: every delivered instruction must match the oldest expectation
    always @(negedge clk_i) begin
        if (!rst_i && req_i && !stall_o) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_instr: got 0x%08h, expected none at %0t", instr_o, $time);
            end else begin
                check("instr", instr_o, exp_q.pop_front());
            end
        end
    end

    // One-cycle hit: expectation is a hand-written constant
    task automatic fetch_hit(input logic [31:0] a, input logic [31:0] exp_instr);
        @(posedge clk_i); #1;
        req_i  = 1'b1;
        addr_i = a;
        exp_q.push_back(exp_instr);
        @(negedge clk_i);
        check("hit_stall", {31'b0, stall_o}, 32'h0);
        check("hit_mem_req", {31'b0, mem_req_o}, 32'h0);
    endtask

    // Miss with ack on the ack_cycle-th MISS cycle, followed by the re-lookup hit
    task automatic fetch_miss(input logic [31:0] a, input int ack_cycle,
                              input logic [31:0] exp_line, input logic [31:0] exp_instr);
        int stalls;
        stalls = 0;
        @(posedge clk_i); #1;
        req_i  = 1'b1;
        addr_i = a;
        exp_q.push_back(exp_instr);
        @(negedge clk_i);
        check("miss_stall0", {31'b0, stall_o}, 32'h1);
        if (stall_o) stalls++;
        for (int j = 1; j <= ack_cycle; j++) begin
            @(posedge clk_i); #1;
            mem_ack_i  = (j == ack_cycle);
            mem_data_i = line_of(a);
            @(negedge clk_i);
            if (stall_o) stalls++;
            if (j == 1) begin
                check("miss_mem_req", {31'b0, mem_req_o}, 32'h1);
                check("miss_mem_addr", mem_addr_o, exp_line);
            end
        end
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        if (stall_o) stalls++;
        check("refill_mem_req", {31'b0, mem_req_o}, 32'h0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("relookup_stall", {31'b0, stall_o}, 32'h0);
        check("stall_cycles", 32'(stalls), 32'(ack_cycle + 2));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i      = 1'b1;
        req_i      = 1'b0;
        addr_i     = 32'h0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;

        // Reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_stall", {31'b0, stall_o}, 32'h0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_mem_req", {31'b0, mem_req_o}, 32'h0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_hit_cnt", hit_cnt_o, 32'h0);
        check("rst_miss_cnt", miss_cnt_o, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // 1: cold miss at 0x0, ack on the third MISS cycle
        fetch_miss(32'h0000_0000, 3, 32'h0000_0000, 32'hC0DE_0000);

        // 2: rest of line 0 hits back to back
        fetch_hit(32'h0000_0004, 32'hC0DE_0004);
        fetch_hit(32'h0000_0008, 32'hC0DE_0008);
        fetch_hit(32'h0000_000C, 32'hC0DE_000C);
        fetch_hit(32'h0000_0010, 32'hC0DE_0010);
        fetch_hit(32'h0000_0014, 32'hC0DE_0014);
        fetch_hit(32'h0000_0018, 32'hC0DE_0018);
        fetch_hit(32'h0000_001C, 32'hC0DE_001C);

        // 3: conflict on index 0
        fetch_miss(32'h0000_0400, 1, 32'h0000_0400, 32'hC0DE_0400);
        fetch_miss(32'h0000_0000, 2, 32'h0000_0000, 32'hC0DE_0000);
        @(posedge clk_i); #1;
        req_i = 1'b0;

        // 6: counters after tests 1-3
        @(negedge clk_i);
`ifdef ICACHE_STATS_EN
        check("hit_cnt", hit_cnt_o, 32'd10);
        check("miss_cnt", miss_cnt_o, 32'd3);
`else
        check("hit_cnt", hit_cnt_o, 32'd0);
        check("miss_cnt", miss_cnt_o, 32'd0);
`endif

        // 4: reset while in MISS, late ack two cycles later
        @(posedge clk_i); #1;
        req_i  = 1'b1;
        addr_i = 32'h0000_0800;
        @(negedge clk_i);
        check("r4_stall", {31'b0, stall_o}, 32'h1);
        @(negedge clk_i);
        check("r4_in_miss", {31'b0, mem_req_o}, 32'h1);
        #2;
        rst_i = 1'b1;
        #1;
        check("r4_mem_req_drop", {31'b0, mem_req_o}, 32'h0);
        check("r4_stall_rst", {31'b0, stall_o}, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        req_i = 1'b0;
        @(posedge clk_i); #1;
        mem_ack_i  = 1'b1;
        mem_data_i = line_of(32'h0000_0800);
        @(negedge clk_i);
        check("r4_late_ack_req", {31'b0, mem_req_o}, 32'h0);
        check("r4_late_ack_stall", {31'b0, stall_o}, 32'h0);
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        fetch_miss(32'h0000_0000, 1, 32'h0000_0000, 32'hC0DE_0000);
        @(posedge clk_i); #1;
        req_i = 1'b0;

        // 5: idle with spurious acks carrying junk data
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_i); #1;
            mem_ack_i = 1'($urandom_range(0, 1));
            for (int w = 0; w < LW; w++) mem_data_i[32*w +: 32] = $urandom;
            @(negedge clk_i);
            check("idle_stall", {31'b0, stall_o}, 32'h0);
            check("idle_instr", instr_o, 32'h0);
            check("idle_mem_req", {31'b0, mem_req_o}, 32'h0);
        end
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        fetch_hit(32'h0000_000C, 32'hC0DE_000C);
        fetch_miss(32'h0000_0020, 1, 32'h0000_0020, 32'hC0DE_0020);
        @(posedge clk_i); #1;
        req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
